// File: rtl/keypad_pkg.sv
// Shared keypad definitions: line patterns, key_pos encoding, digit map, emulator states.
// Latency: n/a (types and pure functions); backpressure: n/a.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  // key_pos = {row_idx, col_idx}; index 0 is the MSB line on both row and column buses
  typedef struct packed {
    logic [1:0] row_idx;
    logic [1:0] col_idx;
  } key_pos_t;

  localparam logic [3:0] LINE_IDLE = 4'b1111;
  localparam logic [3:0] PAT_0     = 4'b0111;
  localparam logic [3:0] PAT_1     = 4'b1011;
  localparam logic [3:0] PAT_2     = 4'b1101;
  localparam logic [3:0] PAT_3     = 4'b1110;

  // Digits in key_pos order, first nibble is key_pos 0; must match the scanning reader
  localparam logic [63:0] DIGIT_MAP = 64'h147F_2580_369F_ABCD;

  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = PAT_0;
      2'd1:    pat = PAT_1;
      2'd2:    pat = PAT_2;
      default: pat = PAT_3;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] key_digit(input key_pos_t pos);
    logic [3:0] p;
    p = pos;
    return DIGIT_MAP[{~p, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_matrix_switch.sv
// Passive switch model: pulls the key's column low while closed and its row is strobed.
// Latency: zero (combinational row->column); backpressure: none.
module keypad_matrix_switch
  import keypad_pkg::*;
(
  input  logic     [3:0] row,
  input  logic           contact,
  input  key_pos_t       key_pos,
  output logic     [3:0] column
);

  logic row_hit;

  // Only the key's own row line matters; other low rows are invisible to this switch
  assign row_hit = (row | one_cold(key_pos.row_idx)) != LINE_IDLE;
  assign column  = (contact && row_hit) ? one_cold(key_pos.col_idx) : LINE_IDLE;

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad emulator: press sequence bounce-in/hold/bounce-out/gap driving a matrix switch.
// Latency: contact changes one cycle after transfer; backpressure: key_ready only in IDLE.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1_500_000,
  parameter int BOUNCE_CYCLES = 50_000,
  parameter int TOGGLE_CYCLES = 5_000,
  parameter int GAP_CYCLES    = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_pos,
  output logic       key_ready,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic       contact,
  output logic       busy,
  output logic       done
);

  localparam int MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_TG  = (TOGGLE_CYCLES > GAP_CYCLES) ? TOGGLE_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_HB > MAX_TG) ? MAX_HB : MAX_TG;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int TGL_W   = $clog2(TOGGLE_CYCLES) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [TGL_W-1:0]   tgl;
  logic [31:0]        limit;
  key_pos_t           pos_q;
  logic               contact_nxt;
  logic               xfer;
  logic               cnt_last;
  logic               bouncing;
  logic               entering;
  logic               entering_bounce;
  logic               tgl_last;

  assign xfer     = key_valid && key_ready;
  assign bouncing = (state == ST_BOUNCE_IN) || (state == ST_BOUNCE_OUT);
  assign cnt_last = (32'(cnt) + 32'd1) >= limit;
  assign tgl_last = bouncing && ((32'(tgl) + 32'd1) >= 32'(TOGGLE_CYCLES));
  assign entering = state_nxt != state;
  assign entering_bounce = entering &&
                           ((state_nxt == ST_BOUNCE_IN) || (state_nxt == ST_BOUNCE_OUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tgl     <= '0;
      contact <= 1'b0;
      done    <= 1'b0;
      pos_q   <= '0;
    end else begin
      state   <= state_nxt;
      contact <= contact_nxt;
      done    <= (state == ST_GAP) && (state_nxt == ST_IDLE);
      if (xfer) begin
        pos_q <= key_pos_t'(key_pos);
      end
      if (entering || (state == ST_IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (entering_bounce || tgl_last) begin
        tgl <= '0;
      end else if (bouncing) begin
        tgl <= tgl + TGL_W'(1);
      end
    end
  end

  always_comb begin
    limit = 32'd0;
    case (state)
      ST_BOUNCE_IN, ST_BOUNCE_OUT: limit = 32'(BOUNCE_CYCLES);
      ST_HOLD:                     limit = 32'(HOLD_CYCLES);
      ST_GAP:                      limit = 32'(GAP_CYCLES);
      default:                     limit = 32'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          state_nxt = (BOUNCE_CYCLES == 0) ? ST_HOLD : ST_BOUNCE_IN;
        end
      end
      ST_BOUNCE_IN: begin
        if (cnt_last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_last) state_nxt = (BOUNCE_CYCLES == 0) ? ST_GAP : ST_BOUNCE_OUT;
      end
      ST_BOUNCE_OUT: begin
        if (cnt_last) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Contact is registered, so it follows the state being entered, not the current one
    contact_nxt = 1'b0;
    case (state_nxt)
      ST_HOLD:       contact_nxt = 1'b1;
      ST_BOUNCE_IN:  contact_nxt = entering ? 1'b1 : (contact ^ tgl_last);
      ST_BOUNCE_OUT: contact_nxt = entering ? 1'b0 : (contact ^ tgl_last);
      default:       contact_nxt = 1'b0;
    endcase
  end

  always_comb begin
    busy      = state != ST_IDLE;
    key_ready = rst && (state == ST_IDLE);
  end

  keypad_matrix_switch u_switch (
    .row     (row),
    .contact (contact),
    .key_pos (pos_q),
    .column  (column)
  );

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: reset, bounced press, row sweep, request spam, no-bounce, abort.
// Latency: n/a; backpressure: n/a.
module tb_keypad_emulator;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid, key_ready, contact, busy, done;
  logic [3:0] key_pos, row, column;
  logic       kv_z, kr_z, contact_z, busy_z, done_z;
  logic [3:0] kp_z, row_z, column_z;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(40), .BOUNCE_CYCLES(10), .TOGGLE_CYCLES(3), .GAP_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_pos(key_pos), .key_ready(key_ready),
    .row(row), .column(column), .contact(contact), .busy(busy), .done(done)
  );

  keypad_emulator #(
    .HOLD_CYCLES(40), .BOUNCE_CYCLES(0), .TOGGLE_CYCLES(3), .GAP_CYCLES(20)
  ) dut_z (
    .clk(clk), .rst(rst), .key_valid(kv_z), .key_pos(kp_z), .key_ready(kr_z),
    .row(row_z), .column(column_z), .contact(contact_z), .busy(busy_z), .done(done_z)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected contact i cycles after the transfer edge (bounce 10, toggle 3, hold 40, gap 20)
  function automatic logic exp_contact(input int i);
    if (i <= 10) return ((i - 1) / 3) % 2 == 0;
    if (i <= 50) return 1'b1;
    if (i <= 60) return ((i - 51) / 3) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] row_pat(input int n);
    case (n % 4)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  // Press key 0110 (digit 8); mode 0 fixed row 1011, 1 row sweep, 2 key_valid spam
  task automatic run_press(input string tag, input int mode);
    logic c;
    key_pos   = 4'b0110;
    key_valid = 1'b1;
    row       = 4'b1011;
    @(posedge clk); #1;
    for (int i = 1; i <= 81; i++) begin
      if (mode == 1) row = row_pat((i - 1) / 5);
      if (mode == 2) begin
        key_valid = (i < 80);
        key_pos   = 4'(i * 5);
      end else begin
        key_valid = 1'b0;
      end
      #1;
      c = exp_contact(i);
      check({tag, ".contact"}, {3'b0, contact}, {3'b0, c});
      check({tag, ".column"}, column, (c && row == 4'b1011) ? 4'b1101 : 4'b1111);
      check({tag, ".done"}, {3'b0, done}, {3'b0, i == 81});
      check({tag, ".busy"}, {3'b0, busy}, {3'b0, i <= 80});
      check({tag, ".ready"}, {3'b0, key_ready}, {3'b0, i == 81});
      if (i < 81) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_pos = 4'b0000; row = 4'b1111;
    kv_z = 1'b0; kp_z = 4'b0000; row_z = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {3'b0, key_ready}, 4'd0);
    check("rst.column", column, 4'b1111);
    check("rst.busy", {3'b0, busy}, 4'd0);
    check("rst.done", {3'b0, done}, 4'd0);
    check("rst.contact", {3'b0, contact}, 4'd0);

    rst = 1'b1;
    row = 4'b0000;
    #1;
    check("idle.ready", {3'b0, key_ready}, 4'd1);
    @(posedge clk); #1;
    check("idle.column", column, 4'b1111);
    check("idle.busy", {3'b0, busy}, 4'd0);
    check("idle.done", {3'b0, done}, 4'd0);

    run_press("press", 0);
    // next request lands in the done cycle of the previous press
    run_press("sweep", 1);
    run_press("spam", 2);

    kp_z = 4'b1111;
    row_z = 4'b1110;
    kv_z = 1'b1;
    @(posedge clk); #1;
    kv_z = 1'b0;
    for (int i = 1; i <= 61; i++) begin
      #1;
      check("nobounce.column", column_z, (i <= 40) ? 4'b1110 : 4'b1111);
      check("nobounce.contact", {3'b0, contact_z}, {3'b0, i <= 40});
      check("nobounce.done", {3'b0, done_z}, {3'b0, i == 61});
      if (i < 61) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    key_pos = 4'b0110;
    row = 4'b1011;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("abort.hold_column", column, 4'b1101);
    check("abort.hold_busy", {3'b0, busy}, 4'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort.column", column, 4'b1111);
    check("abort.busy", {3'b0, busy}, 4'd0);
    check("abort.done", {3'b0, done}, 4'd0);
    check("abort.ready_in_rst", {3'b0, key_ready}, 4'd0);
    rst = 1'b1;
    #1;
    check("abort.ready", {3'b0, key_ready}, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort.no_done", {3'b0, done}, 4'd0);
      check("abort.idle_column", column, 4'b1111);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
